// File: rtl/cgra_clk_gate_pkg.sv
// Shared types and sizing helpers for the CGRA clock-gate enable controller.
package cgra_clk_gate_pkg;

  // Per-domain gating state.
  typedef enum logic [1:0] {
    CG_OFF  = 2'd0,
    CG_WAKE = 2'd1,
    CG_ON   = 2'd2,
    CG_IDLE = 2'd3
  } cg_state_e;

  // Default configuration.
  localparam int unsigned CG_N_DOM_DEF = 4;
  localparam int unsigned CG_WAKE_DEF  = 2;
  localparam int unsigned CG_HYST_DEF  = 8;

  function automatic int unsigned cg_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width of the shared wake/hysteresis down-counter.
  function automatic int unsigned cg_cnt_width(input int unsigned wake, input int unsigned hyst);
    return $clog2(cg_max(wake, hyst)) + 1;
  endfunction

  localparam int unsigned CG_CNT_W_DEF = cg_cnt_width(CG_WAKE_DEF, CG_HYST_DEF);

endpackage

// File: rtl/cgra_clk_gate_ctrl_if.sv
// Request/busy/enable/acknowledge bundle between domain clients and the gate controller.
interface cgra_clk_gate_ctrl_if
  import cgra_clk_gate_pkg::*;
#(
  parameter int unsigned N_DOM = CG_N_DOM_DEF
);

  logic [N_DOM-1:0] req_i;
  logic [N_DOM-1:0] busy_i;
  logic [N_DOM-1:0] en_o;
  logic [N_DOM-1:0] ack_o;

  // Client side: raises requests and busy flags, observes enables and acks.
  modport master (
    output req_i,
    output busy_i,
    input  en_o,
    input  ack_o
  );

  // Controller side.
  modport slave (
    input  req_i,
    input  busy_i,
    output en_o,
    output ack_o
  );

endinterface

// File: rtl/cgra_clk_gate_dom_fsm.sv
// Single clock-domain gating FSM: OFF -> WAKE -> ON <-> IDLE -> OFF.
module cgra_clk_gate_dom_fsm
  import cgra_clk_gate_pkg::*;
#(
  parameter int unsigned WAKE_CYCLES = CG_WAKE_DEF,
  parameter int unsigned HYST_CYCLES = CG_HYST_DEF,
  parameter int unsigned CNT_W       = cg_cnt_width(WAKE_CYCLES, HYST_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic busy,
  output logic en,
  output logic ack,
  output logic off_next
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HYST_LOAD = CNT_W'((HYST_CYCLES == 32'd0) ? 32'd0 : HYST_CYCLES - 32'd1);

  cg_state_e        state;
  cg_state_e        state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  // Next-state and counter update. WAKE and IDLE are never live at the same
  // time, so a single counter serves as both the settle and hysteresis timer.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      CG_OFF: begin
        if (req) begin
          state_d = CG_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      CG_WAKE: begin
        if (cnt == '0) state_d = CG_ON;
        else           cnt_d   = cnt - 1'b1;
      end
      CG_ON: begin
        if (!req && !busy) begin
          if (HYST_CYCLES == 32'd0) begin
            state_d = CG_OFF;
          end else begin
            state_d = CG_IDLE;
            cnt_d   = HYST_LOAD;
          end
        end
      end
      CG_IDLE: begin
        if (req || busy)    state_d = CG_ON;
        else if (cnt == '0) state_d = CG_OFF;
        else                cnt_d   = cnt - 1'b1;
      end
      default: state_d = CG_OFF;
    endcase
  end

  assign off_next = (state_d == CG_OFF);

  // State, counter and registered enable/ack derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CG_OFF;
      cnt   <= '0;
      en    <= 1'b0;
      ack   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      en    <= (state_d != CG_OFF);
      ack   <= (state_d == CG_ON) || (state_d == CG_IDLE);
    end
  end

  // An acknowledged domain always has its clock enabled.
  ack_implies_en : assert property (@(posedge clk) disable iff (rst) ack |-> en);

  // The counter only ever holds a reload value or something below it.
  cnt_bounded : assert property (@(posedge clk) disable iff (rst)
    (cnt <= WAKE_LOAD) || (cnt <= HYST_LOAD));

endmodule

// File: rtl/cgra_clk_gate_ctrl.sv
// Per-domain clock-gate enable generation for the CGRA, on the free-running clock.
module cgra_clk_gate_ctrl
  import cgra_clk_gate_pkg::*;
#(
  parameter int unsigned N_DOM       = CG_N_DOM_DEF,
  parameter int unsigned WAKE_CYCLES = CG_WAKE_DEF,
  parameter int unsigned HYST_CYCLES = CG_HYST_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 force_on_i,
  cgra_clk_gate_ctrl_if.slave  gate,
  output logic                 all_off_o
);

  localparam int unsigned CNT_W = cg_cnt_width(WAKE_CYCLES, HYST_CYCLES);

  logic [N_DOM-1:0] en_q;
  logic [N_DOM-1:0] ack_q;
  logic [N_DOM-1:0] off_next;

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    cgra_clk_gate_dom_fsm #(
      .WAKE_CYCLES (WAKE_CYCLES),
      .HYST_CYCLES (HYST_CYCLES),
      .CNT_W       (CNT_W)
    ) u_fsm (
      .clk      (clk_i),
      .rst      (rst_i),
      .req      (gate.req_i[i]),
      .busy     (gate.busy_i[i]),
      .en       (en_q[i]),
      .ack      (ack_q[i]),
      .off_next (off_next[i])
    );
  end

  // The override is the only combinational path to the gate enables.
  assign gate.en_o  = en_q | {N_DOM{force_on_i}};
  assign gate.ack_o = ack_q;

  // Registered "every domain is off" flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) all_off_o <= 1'b1;
    else       all_off_o <= &off_next;
  end

endmodule

// File: tb/tb_cgra_clk_gate_ctrl.sv
// Self-checking bench for cgra_clk_gate_ctrl: directed scenarios plus random traffic
// against a cycle-counting reference model, on two parameterisations.
module tb_cgra_clk_gate_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         force_on;
  logic [N-1:0] req;
  logic [N-1:0] busy;
  logic         all_off0;
  logic         all_off1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cgra_clk_gate_ctrl_if #(.N_DOM(N)) bus0 ();
  cgra_clk_gate_ctrl_if #(.N_DOM(N)) bus1 ();

  assign bus0.req_i  = req;
  assign bus0.busy_i = busy;
  assign bus1.req_i  = req;
  assign bus1.busy_i = busy;

  always #5 clk = ~clk;

  cgra_clk_gate_ctrl #(.N_DOM(N), .WAKE_CYCLES(2), .HYST_CYCLES(8)) u_dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .force_on_i (force_on),
    .gate       (bus0),
    .all_off_o  (all_off0)
  );

  cgra_clk_gate_ctrl #(.N_DOM(N), .WAKE_CYCLES(1), .HYST_CYCLES(0)) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .force_on_i (force_on),
    .gate       (bus1),
    .all_off_o  (all_off1)
  );

  // Reference model: a domain is powered or not; a powered domain has a number of
  // settle cycles still to run, and once settled counts consecutive idle cycles.
  bit pw[2][N];
  int wl[2][N];
  int ir[2][N];

  function automatic int mw(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int mh(int k);
    return (k == 0) ? 8 : 0;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < N; d++) begin
        if (rst) begin
          pw[k][d] = 1'b0; wl[k][d] = 0; ir[k][d] = 0;
        end else if (!pw[k][d]) begin
          if (req[d]) begin
            pw[k][d] = 1'b1; wl[k][d] = mw(k); ir[k][d] = 0;
          end
        end else if (wl[k][d] > 0) begin
          wl[k][d]--;
        end else begin
          if (req[d] || busy[d]) ir[k][d] = 0;
          else                   ir[k][d]++;
          if (ir[k][d] > mh(k)) begin
            pw[k][d] = 1'b0; ir[k][d] = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [N-1:0] m_en(int k);
    logic [N-1:0] r;
    for (int d = 0; d < N; d++) r[d] = pw[k][d] | force_on;
    return r;
  endfunction

  function automatic logic [N-1:0] m_ack(int k);
    logic [N-1:0] r;
    for (int d = 0; d < N; d++) r[d] = pw[k][d] && (wl[k][d] == 0);
    return r;
  endfunction

  function automatic logic m_off(int k);
    logic r;
    r = 1'b1;
    for (int d = 0; d < N; d++) if (pw[k][d]) r = 1'b0;
    return r;
  endfunction

  // One clock: model advances on the edge, outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; busy = '0; force_on = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; busy = '0; force_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus0.en_o, bus0.ack_o, all_off0} !== {4'h0, 4'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: en=%b ack=%b all_off=%b, expected en=0000 ack=0000 all_off=1",
                 i, bus0.en_o, bus0.ack_o, all_off0);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus0.en_o, bus0.ack_o, all_off0} !== {4'hF, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: en=%b ack=%b all_off=%b, expected en=1111 ack=0000 all_off=0",
               bus0.en_o, bus0.ack_o, all_off0);
    end
  endtask

  task automatic test_wake();
    logic [N-1:0] e_ack;
    do_reset();
    req = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      e_ack = (k >= 3) ? 4'b0001 : 4'b0000;
      n_checks++;
      if ({bus0.en_o, bus0.ack_o, all_off0} !== {4'b0001, e_ack, 1'b0}) begin
        n_fail++;
        $display("FAIL wake k=%0d: en=%b ack=%b all_off=%b, expected en=0001 ack=%b all_off=0",
                 k, bus0.en_o, bus0.ack_o, all_off0, e_ack);
      end
    end
  endtask

  task automatic test_hysteresis();
    logic [N-1:0] e;
    do_reset();
    req = 4'b0010;
    repeat (4) tick();
    req = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = (k <= 8) ? 4'b0010 : 4'b0000;
      n_checks++;
      if ({bus0.en_o, bus0.ack_o, all_off0} !== {e, e, (k > 8)}) begin
        n_fail++;
        $display("FAIL hysteresis k=%0d: en=%b ack=%b all_off=%b, expected en=%b ack=%b all_off=%b",
                 k, bus0.en_o, bus0.ack_o, all_off0, e, e, (k > 8));
      end
    end
  endtask

  task automatic test_rerequest();
    logic [N-1:0] e;
    do_reset();
    req = 4'b0100;
    repeat (4) tick();
    req = '0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) req = 4'b0100;
      tick();
      n_checks++;
      if ({bus0.en_o, bus0.ack_o} !== {4'b0100, 4'b0100}) begin
        n_fail++;
        $display("FAIL rerequest_hold k=%0d: en=%b ack=%b, expected en=0100 ack=0100",
                 k, bus0.en_o, bus0.ack_o);
      end
    end
    // Full hysteresis again proves the domain went back to ON with a fresh timer.
    req = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = (k <= 8) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (bus0.en_o !== e) begin
        n_fail++;
        $display("FAIL rerequest_release k=%0d: en=%b, expected %b", k, bus0.en_o, e);
      end
    end
  endtask

  task automatic test_busy_hold();
    logic [N-1:0] e;
    do_reset();
    req = 4'b1000; busy = 4'b1000;
    repeat (4) tick();
    req = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if ({bus0.en_o, bus0.ack_o} !== {4'b1000, 4'b1000}) begin
        n_fail++;
        $display("FAIL busy_hold k=%0d: en=%b ack=%b, expected en=1000 ack=1000",
                 k, bus0.en_o, bus0.ack_o);
      end
    end
    busy = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = (k <= 8) ? 4'b1000 : 4'b0000;
      n_checks++;
      if (bus0.en_o !== e) begin
        n_fail++;
        $display("FAIL busy_release k=%0d: en=%b, expected %b", k, bus0.en_o, e);
      end
    end
    busy = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if ({bus0.en_o, bus0.ack_o, all_off0} !== {4'h0, 4'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL busy_no_wake k=%0d: en=%b ack=%b all_off=%b, expected en=0000 ack=0000 all_off=1",
                 k, bus0.en_o, bus0.ack_o, all_off0);
      end
    end
    busy = '0;
  endtask

  task automatic test_force_and_reset();
    do_reset();
    force_on = 1'b1;
    #1;
    n_checks++;
    if ({bus0.en_o, bus0.ack_o, all_off0} !== {4'hF, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL force_same_cycle: en=%b ack=%b all_off=%b, expected en=1111 ack=0000 all_off=1",
               bus0.en_o, bus0.ack_o, all_off0);
    end
    tick();
    n_checks++;
    if ({bus0.en_o, bus0.ack_o, all_off0} !== {4'hF, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL force_held: en=%b ack=%b all_off=%b, expected en=1111 ack=0000 all_off=1",
               bus0.en_o, bus0.ack_o, all_off0);
    end
    force_on = 1'b0;
    #1;
    n_checks++;
    if (bus0.en_o !== 4'h0) begin
      n_fail++;
      $display("FAIL force_release: en=%b, expected 0000", bus0.en_o);
    end
    req = 4'b0001;
    tick();
    n_checks++;
    if (bus0.en_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL midwake_enter: en=%b, expected 0001", bus0.en_o);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus0.en_o, bus0.ack_o, all_off0} !== {4'h0, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL midwake_reset: en=%b ack=%b all_off=%b, expected en=0000 ack=0000 all_off=1",
               bus0.en_o, bus0.ack_o, all_off0);
    end
    rst = 1'b0; req = '0;
    repeat (3) tick();
    n_checks++;
    if ({bus0.en_o, bus0.ack_o} !== {4'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL midwake_no_memory: en=%b ack=%b, expected en=0000 ack=0000",
               bus0.en_o, bus0.ack_o);
    end
  endtask

  task automatic test_random();
    bit quiet;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      quiet = ((i / 150) % 2) == 1;
      for (int d = 0; d < N; d++) begin
        req[d]  = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
        busy[d] = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      end
      force_on = ($urandom_range(0, 19) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
      n_checks++;
      if ({bus0.en_o, bus0.ack_o, all_off0} !== {m_en(0), m_ack(0), m_off(0)}) begin
        n_fail++;
        $display("FAIL random_w2h8 i=%0d: en=%b ack=%b all_off=%b, expected en=%b ack=%b all_off=%b",
                 i, bus0.en_o, bus0.ack_o, all_off0, m_en(0), m_ack(0), m_off(0));
      end
      n_checks++;
      if ({bus1.en_o, bus1.ack_o, all_off1} !== {m_en(1), m_ack(1), m_off(1)}) begin
        n_fail++;
        $display("FAIL random_w1h0 i=%0d: en=%b ack=%b all_off=%b, expected en=%b ack=%b all_off=%b",
                 i, bus1.en_o, bus1.ack_o, all_off1, m_en(1), m_ack(1), m_off(1));
      end
    end
    rst = 1'b0; force_on = 1'b0; req = '0; busy = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; busy = '0; force_on = 1'b0;
    test_reset();
    test_wake();
    test_hysteresis();
    test_rerequest();
    test_busy_hold();
    test_force_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
